// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
// Holds the funct3 encodings, the FSM state type and small decode helpers.
// Optional feature macro: MULDIV_SIGNED_EN enables signed RV32M semantics.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
//   start/funct3/a/b : request (driven by master)
//   busy/done/result : status and registered result (driven by slave)
interface muldiv_if #(
  parameter int unsigned N = 32
);
  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (output start, funct3, a, b, input busy, done, result);
  modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// Combinational single iteration of the mul/div datapath.
//   acc_i/mq_i   : upper (partial product / remainder) and lower (multiplier / quotient) halves
//   operand_i    : multiplicand or divisor magnitude
//   div_mode_i   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_o/mq_o   : halves after this iteration
module muldiv_step #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] mq_i,
  input  logic [N-1:0] operand_i,
  input  logic         div_mode_i,
  output logic [N-1:0] acc_o,
  output logic [N-1:0] mq_o
);

  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    acc_o   = acc_i;
    mq_o    = mq_i;
    if (div_mode_i) begin
      // Shift next dividend bit into the remainder, then trial-subtract.
      // diff[N] set means the subtraction borrowed: restore.
      shifted = {acc_i, mq_i[N-1]};
      diff    = shifted - {1'b0, operand_i};
      mq_o    = {mq_i[N-2:0], ~diff[N]};
      acc_o   = diff[N] ? shifted[N-1:0] : diff[N-1:0];
    end else begin
      // Add multiplicand when the current multiplier LSB is set, then shift the
      // 2N-bit {acc, mq} right by one with the carry entering at the top.
      sum   = {1'b0, acc_i} + (mq_i[0] ? {1'b0, operand_i} : '0);
      acc_o = sum[N:1];
      mq_o  = {sum[0], mq_i[N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (N-cycle shift-add / restoring divide).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : muldiv_if slave (start/funct3/a/b in, busy/done/result out)
// Divide-by-zero (and signed DIV/REM overflow) complete without entering BUSY.
// Macro MULDIV_SIGNED_EN: signed MULH/MULHSU/DIV/REM; undefined, they act unsigned.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    mq_q, mq_d;
  logic [N-1:0]    op_q, op_d;
  logic [N-1:0]    result_q, result_d;
  logic [2:0]      f3_q, f3_d;

  logic [N-1:0]    acc_nx, mq_nx;
  logic [N-1:0]    a_mag, b_mag;
  logic            div_ovf;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quo, rem, final_res;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;
`endif

  muldiv_step #(.N(N)) u_step (
    .acc_i      (acc_q),
    .mq_i       (mq_q),
    .operand_i  (op_q),
    .div_mode_i (is_div(f3_q)),
    .acc_o      (acc_nx),
    .mq_o       (mq_nx)
  );

  // Result of the final iteration, sign-corrected and selected by op.
  always_comb begin
    prod = {acc_nx, mq_nx};
    quo  = mq_nx;
    rem  = acc_nx;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
      rem  = -rem;
    end
`endif
    if (is_div(f3_q)) begin
      final_res = f3_q[1] ? rem : quo;
    end else if (f3_q == F3_MUL) begin
      final_res = prod[N-1:0];
    end else begin
      final_res = prod[2*N-1:N];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    op_d     = op_q;
    f3_d     = f3_q;
    result_d = result_q;
    a_mag    = bus.a;
    b_mag    = bus.b;
    div_ovf  = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
    a_neg    = a_is_signed(bus.funct3) & bus.a[N-1];
    b_neg    = b_is_signed(bus.funct3) & bus.b[N-1];
    if (a_neg) a_mag = ~bus.a + 1'b1;
    if (b_neg) b_mag = ~bus.b + 1'b1;
    // Most-negative / -1 overflows the quotient; answer is fixed by the ISA.
    div_ovf  = is_div(bus.funct3) && b_is_signed(bus.funct3) &&
               (bus.a == {1'b1, {(N-1){1'b0}}}) && (&bus.b);
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          f3_d  = bus.funct3;
          cnt_d = '0;
          acc_d = '0;
          // Divide iterates over the dividend; multiply over the multiplier.
          op_d  = is_div(bus.funct3) ? b_mag : a_mag;
          mq_d  = is_div(bus.funct3) ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
          // Remainder takes the dividend's sign; everything else the XOR.
          neg_d = (bus.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
`endif
          if (is_div(bus.funct3) && (bus.b == '0)) begin
            state_d  = ST_DONE;
            result_d = bus.funct3[1] ? bus.a : '1;
          end else if (div_ovf) begin
            state_d  = ST_DONE;
            result_d = bus.funct3[1] ? '0 : bus.a;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = acc_nx;
        mq_d  = mq_nx;
        if (cnt_q == CntW'(N - 1)) begin
          state_d  = ST_DONE;
          result_d = final_res;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      op_q     <= '0;
      result_q <= '0;
      f3_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      op_q     <= op_d;
      result_q <= result_d;
      f3_q     <= f3_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end
`endif

  assign bus.busy   = (state_q == ST_BUSY);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized operations
// checked against an arithmetic reference model (honours MULDIV_SIGNED_EN).
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned N = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit Sgn = 1'b1;
`else
  localparam bit Sgn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  muldiv_if #(.N(N)) bus ();

  muldiv_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the RV32M definitions. lat is the
  // cycle (after the accept edge) in which done is expected.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    logic [63:0] ua, ub, up;
    longint      sa, sb, sp;
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    up  = ua * ub;
    sp  = 0;
    lat = N + 1;
    case (f3)
      F3_MUL:   return up[31:0];
      F3_MULH: begin
        if (Sgn) begin sp = sa * sb; return sp[63:32]; end
        return up[63:32];
      end
      F3_MULHSU: begin
        if (Sgn) begin sp = sa * longint'(ua); return sp[63:32]; end
        return up[63:32];
      end
      F3_MULHU: return up[63:32];
      default: begin
        if (b == 32'h0) begin
          lat = 1;
          return f3[1] ? a : 32'hFFFF_FFFF;
        end
        if (Sgn && !f3[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lat = 1;
            return f3[1] ? 32'h0 : a;
          end
          sp = f3[1] ? (sa % sb) : (sa / sb);
          return sp[31:0];
        end
        up = f3[1] ? (ua % ub) : (ua / ub);
        return up[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request and observes the following N+4 cycles. Cycle k is the
  // interval after the k-th edge following the accept edge. A stray start is
  // pulsed at cycle stray_at when stray_at > 0.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int stray_at, output int done_at, output int busy_n,
                        output int busy_last, output int done_n, output logic [31:0] res,
                        output logic [31:0] res_end);
    done_at   = -1;
    busy_n    = 0;
    busy_last = -1;
    done_n    = 0;
    res       = 'x;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.a      = $urandom;
    bus.b      = $urandom;
    for (int k = 1; k <= int'(N) + 4; k++) begin
      if (bus.busy) begin busy_n++; busy_last = k; end
      if (bus.done) begin
        done_n++;
        if (done_at < 0) begin done_at = k; res = bus.result; end
      end
      if (stray_at > 0 && k == stray_at) begin
        bus.start  = 1'b1;
        bus.funct3 = F3_MULHU;
        bus.a      = $urandom;
        bus.b      = $urandom;
      end else if (stray_at > 0 && k == stray_at + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    res_end = bus.result;
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;
    rst_n      = 1'b0;
    #12;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [8] = '{F3_MULHU, F3_MUL, F3_DIVU, F3_REMU, F3_DIVU, F3_REMU, F3_MUL, F3_MULHU};
    logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h1234,
                             32'd6, 32'd0};
    logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] exp [8] = '{32'h1, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234,
                             32'd42, 32'd0};
    int          lat [8] = '{33, 33, 33, 33, 1, 1, 33, 33};
    int done_at, busy_n, busy_last, done_n;
    logic [31:0] res, res_end;
    for (int i = 0; i < 8; i++) begin
      run_op(f3s[i], as[i], bs[i], 0, done_at, busy_n, busy_last, done_n, res, res_end);
      total++;
      if (res !== exp[i]) begin
        bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, exp[i]);
      end
      total++;
      if (done_at !== lat[i]) begin
        bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, done_at, lat[i]);
      end
      total++;
      if (busy_n !== (lat[i] == 1 ? 0 : 32) || (lat[i] != 1 && busy_last !== 32)) begin
        bad++; $display("FAIL dir%0d_busy count=%0d last=%0d", i, busy_n, busy_last);
      end
      total++;
      if (done_n !== 1 || res_end !== exp[i]) begin
        bad++; $display("FAIL dir%0d_hold dones=%0d res_end=%h want=%h", i, done_n, res_end, exp[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [2:0]  f3s [3] = '{F3_DIV, F3_REM, F3_DIV};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] exp [3];
    int          lat [3];
    int done_at, busy_n, busy_last, done_n;
    logic [31:0] res, res_end;
    if (Sgn) begin
      exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
      lat = '{33, 33, 1};
    end else begin
      exp = '{32'h7FFF_FFFC, 32'h1, 32'h0};
      lat = '{33, 33, 33};
    end
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], as[i], bs[i], 0, done_at, busy_n, busy_last, done_n, res, res_end);
      total++;
      if (res !== exp[i] || done_at !== lat[i]) begin
        bad++; $display("FAIL signed%0d got=%h@%0d want=%h@%0d", i, res, done_at, exp[i], lat[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int done_at, busy_n, busy_last, done_n, lat;
    logic [31:0] a, b, exp, res, res_end;
    a   = $urandom;
    b   = $urandom | 32'h1;
    exp = model(F3_DIVU, a, b, lat);
    run_op(F3_DIVU, a, b, 10, done_at, busy_n, busy_last, done_n, res, res_end);
    total++;
    if (res !== exp || res_end !== exp) begin
      bad++; $display("FAIL busy_start_result got=%h end=%h want=%h", res, res_end, exp);
    end
    total++;
    if (done_n !== 1 || done_at !== lat) begin
      bad++; $display("FAIL busy_start_done dones=%0d at=%0d want=1 at %0d", done_n, done_at, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    logic [31:0] got [2];
    int          at  [2];
    int          l1, l2, dn;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = $urandom | 32'h1;
    e1 = model(F3_MULHU, a1, b1, l1);
    e2 = model(F3_REMU, a2, b2, l2);
    dn = 0;
    bus.start = 1'b1; bus.funct3 = F3_MULHU; bus.a = a1; bus.b = b1;
    @(posedge clk); #1;
    bus.funct3 = F3_REMU; bus.a = a2; bus.b = b2;
    for (int k = 1; k <= 80; k++) begin
      if (bus.done) begin
        if (dn < 2) begin got[dn] = bus.result; at[dn] = k; end
        dn++;
      end
      if (k == 40) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (dn !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", dn); end
    if (dn >= 2) begin
      total++;
      if (got[0] !== e1 || at[0] !== l1) begin
        bad++; $display("FAIL b2b_first got=%h@%0d want=%h@%0d", got[0], at[0], e1, l1);
      end
      total++;
      if (got[1] !== e2 || at[1] !== l1 + 1 + l2) begin
        bad++; $display("FAIL b2b_second got=%h@%0d want=%h@%0d", got[1], at[1], e2, l1 + 1 + l2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dn, bz, done_at, busy_n, busy_last, done_n;
    logic [31:0] res, res_end;
    dn = 0;
    bz = 0;
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.a = $urandom; bus.b = $urandom | 32'h1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      bad++; $display("FAIL midreset_outputs busy=%b done=%b result=%h want 0/0/0",
                      bus.busy, bus.done, bus.result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) dn++;
      if (bus.busy) bz++;
      @(posedge clk); #1;
    end
    total++;
    if (dn !== 0 || bz !== 0) begin
      bad++; $display("FAIL midreset_abort dones=%0d busy_cycles=%0d want 0/0", dn, bz);
    end
    run_op(F3_MUL, 32'd6, 32'd7, 0, done_at, busy_n, busy_last, done_n, res, res_end);
    total++;
    if (res !== 32'd42 || done_at !== 33) begin
      bad++; $display("FAIL midreset_mul got=%0d@%0d want=42@33", res, done_at);
    end
  endtask

  task automatic test_random();
    int done_at, busy_n, busy_last, done_n, lat;
    logic [2:0]  f3;
    logic [31:0] a, b, exp, res, res_end;
    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      exp = model(f3, a, b, lat);
      run_op(f3, a, b, 0, done_at, busy_n, busy_last, done_n, res, res_end);
      total++;
      if (res !== exp || done_at !== lat || done_n !== 1 || busy_n !== (lat == 1 ? 0 : 32)) begin
        bad++;
        $display("FAIL rand%0d f3=%0d a=%h b=%h got=%h@%0d busy=%0d dones=%0d want=%h@%0d",
                 i, f3, a, b, res, done_at, busy_n, done_n, exp, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_signed();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
